dmem_responder: RTL



---
 rtl/dmem_responder.sv | 315 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder for a single-cycle core's load/store port.  It holds
// a word-organised RAM and a small memory-mapped I/O block (GPIO register,
// free-running timer with compare, sticky status flags).  Loads are answered
// combinationally in the same cycle.  Stores commit on the rising clock edge.
//
// Optional build macro: DMEM_TIMER_EN
//   defined   : MTIME / MTIMECMP / timer-pending logic is built.
//   undefined : MTIME and MTIMECMP read 0, STATUS bit0 reads 0,
//               TimerIrq is tied low and no counter logic exists.
//
// Address map (byte addresses):
//   0x0000_0000 .. DEPTH*4-1 : RAM
//   0x8000_0000              : GPIO      (RW, low GPIO_W bits)
//   0x8000_0004              : MTIME     (RW)
//   0x8000_0008              : MTIMECMP  (RW)
//   0x8000_000C              : STATUS    (bit0 timer pending, bit1 misalign,
//                                         write-1-to-clear)
//   anything else            : reads 0, writes ignored
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   MemWrite    in   store strobe
//   ByteAccess  in   2  access size: 00 word, 01 half, 10 byte, 11 word
//   DataAdr     in   32 byte address
//   WriteData   in   32 store data, right-justified
//   ReadData    out  32 load data, right-justified, zero-extended
//   GpioOut     out  GPIO_W GPIO register
//   TimerIrq    out  timer pending level
//   MisalignErr out  sticky misaligned-access flag
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH  = 1024,
    parameter int GPIO_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic [1:0]        ByteAccess,
    input  logic [31:0]       DataAdr,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic [GPIO_W-1:0] GpioOut,
    output logic              TimerIrq,
    output logic              MisalignErr
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam logic [1:0] IO_GPIO     = 2'd0;
    localparam logic [1:0] IO_MTIME    = 2'd1;
    localparam logic [1:0] IO_MTIMECMP = 2'd2;
    localparam logic [1:0] IO_STATUS   = 2'd3;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    logic          misalign_s;
    logic          word_acc_s;
    logic          ram_sel_s;
    logic          io_sel_s;
    logic          wr_ok_s;
    logic          ram_we_s;
    logic          io_we_s;
    logic          gpio_we_s;
    logic          status_we_s;
    logic [AW-1:0] ram_idx_s;

    // Size/alignment classification; reserved size 11 behaves as a word.
    always_comb begin
        misalign_s = 1'b0;
        word_acc_s = 1'b1;
        case (ByteAccess)
            SZ_BYTE: begin
                misalign_s = 1'b0;
                word_acc_s = 1'b0;
            end
            SZ_HALF: begin
                misalign_s = DataAdr[0];
                word_acc_s = 1'b0;
            end
            default: begin
                misalign_s = (DataAdr[1:0] != 2'b00);
                word_acc_s = 1'b1;
            end
        endcase
    end

    // Region select and write strobes; a store during reset is dropped everywhere.
    always_comb begin
        ram_sel_s   = ((DataAdr >> (AW + 2)) == 32'd0);
        io_sel_s    = (DataAdr[31:4] == 28'h800_0000);
        ram_idx_s   = DataAdr[AW+1:2];
        wr_ok_s     = MemWrite && !reset && !misalign_s;
        ram_we_s    = wr_ok_s && ram_sel_s;
        // I/O registers only accept full-word stores.
        io_we_s     = wr_ok_s && io_sel_s && word_acc_s;
        gpio_we_s   = io_we_s && (DataAdr[3:2] == IO_GPIO);
        status_we_s = io_we_s && (DataAdr[3:2] == IO_STATUS);
    end

    // ------------------------------------------------------------------
    // RAM
    // ------------------------------------------------------------------
    logic [31:0] mem_q [DEPTH];
    logic [3:0]  ram_be_s;
    logic [31:0] ram_wdata_s;
    logic [31:0] ram_rdata_s;

    // Lane enables; store data is replicated so every enabled lane sees its bytes.
    always_comb begin
        ram_be_s    = 4'b1111;
        ram_wdata_s = WriteData;
        case (ByteAccess)
            SZ_BYTE: begin
                ram_be_s    = 4'b0001 << DataAdr[1:0];
                ram_wdata_s = {4{WriteData[7:0]}};
            end
            SZ_HALF: begin
                ram_be_s    = DataAdr[1] ? 4'b1100 : 4'b0011;
                ram_wdata_s = {2{WriteData[15:0]}};
            end
            default: begin
                ram_be_s    = 4'b1111;
                ram_wdata_s = WriteData;
            end
        endcase
    end

    // RAM byte-lane write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_be_s[i]) begin
                    mem_q[ram_idx_s][8*i +: 8] <= ram_wdata_s[8*i +: 8];
                end
            end
        end
    end

    assign ram_rdata_s = mem_q[ram_idx_s];

    // ------------------------------------------------------------------
    // GPIO register
    // ------------------------------------------------------------------
    logic [GPIO_W-1:0] gpio_d;
    logic [GPIO_W-1:0] gpio_q;

    // GPIO next value.
    always_comb begin
        gpio_d = gpio_q;
        if (gpio_we_s) begin
            gpio_d = WriteData[GPIO_W-1:0];
        end else begin
            gpio_d = gpio_q;
        end
    end

    // GPIO register.
    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_q <= {GPIO_W{1'b0}};
        end else begin
            gpio_q <= gpio_d;
        end
    end

    // ------------------------------------------------------------------
    // Sticky misalignment flag
    // ------------------------------------------------------------------
    logic misalign_d;
    logic misalign_q;

    // Any misaligned cycle sets the flag; a set beats a simultaneous clear.
    always_comb begin
        misalign_d = misalign_q;
        if (misalign_s) begin
            misalign_d = 1'b1;
        end else if (status_we_s && WriteData[1]) begin
            misalign_d = 1'b0;
        end else begin
            misalign_d = misalign_q;
        end
    end

    // Misalignment flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    // ------------------------------------------------------------------
    // Timer
    // ------------------------------------------------------------------
    logic [31:0] mtime_rd_s;
    logic [31:0] mtimecmp_rd_s;
    logic        timer_pend_s;

`ifdef DMEM_TIMER_EN
    logic [31:0] mtime_d;
    logic [31:0] mtime_q;
    logic [31:0] mtimecmp_d;
    logic [31:0] mtimecmp_q;
    logic        pend_d;
    logic        pend_q;
    logic        mtime_we_s;
    logic        mtimecmp_we_s;

    assign mtime_we_s    = io_we_s && (DataAdr[3:2] == IO_MTIME);
    assign mtimecmp_we_s = io_we_s && (DataAdr[3:2] == IO_MTIMECMP);

    // Counter load/increment, compare register, and pending flag.
    // The match uses the pre-increment count; a set beats a simultaneous clear.
    always_comb begin
        mtime_d    = mtime_q + 32'd1;
        mtimecmp_d = mtimecmp_q;
        pend_d     = pend_q;
        if (mtime_we_s) begin
            mtime_d = WriteData;
        end else begin
            mtime_d = mtime_q + 32'd1;
        end
        if (mtimecmp_we_s) begin
            mtimecmp_d = WriteData;
        end else begin
            mtimecmp_d = mtimecmp_q;
        end
        if (mtime_q == mtimecmp_q) begin
            pend_d = 1'b1;
        end else if (status_we_s && WriteData[0]) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
    end

    // Timer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mtime_q    <= 32'h0000_0000;
            mtimecmp_q <= 32'hFFFF_FFFF;
            pend_q     <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            pend_q     <= pend_d;
        end
    end

    assign mtime_rd_s    = mtime_q;
    assign mtimecmp_rd_s = mtimecmp_q;
    assign timer_pend_s  = pend_q;
`else
    assign mtime_rd_s    = 32'h0000_0000;
    assign mtimecmp_rd_s = 32'h0000_0000;
    assign timer_pend_s  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------
    logic [31:0] io_rdata_s;
    logic [31:0] sel_word_s;
    logic [31:0] lane_s;

    // I/O register read mux, indexed by word within the I/O block.
    always_comb begin
        io_rdata_s = 32'h0000_0000;
        case (DataAdr[3:2])
            IO_GPIO:     io_rdata_s = 32'(gpio_q);
            IO_MTIME:    io_rdata_s = mtime_rd_s;
            IO_MTIMECMP: io_rdata_s = mtimecmp_rd_s;
            IO_STATUS:   io_rdata_s = {30'd0, misalign_q, timer_pend_s};
            default:     io_rdata_s = 32'h0000_0000;
        endcase
    end

    // Region select, lane shift-down and zero extension; misaligned loads read 0.
    always_comb begin
        sel_word_s = 32'h0000_0000;
        if (ram_sel_s) begin
            sel_word_s = ram_rdata_s;
        end else if (io_sel_s) begin
            sel_word_s = io_rdata_s;
        end else begin
            sel_word_s = 32'h0000_0000;
        end

        lane_s   = sel_word_s >> {DataAdr[1:0], 3'b000};
        ReadData = 32'h0000_0000;
        if (misalign_s) begin
            ReadData = 32'h0000_0000;
        end else begin
            case (ByteAccess)
                SZ_BYTE: ReadData = {24'h00_0000, lane_s[7:0]};
                SZ_HALF: ReadData = {16'h0000, lane_s[15:0]};
                default: ReadData = sel_word_s;
            endcase
        end
    end

    assign GpioOut     = gpio_q;
    assign TimerIrq    = timer_pend_s;
    assign MisalignErr = misalign_q;

endmodule
